// File: rtl/sync_pkg.sv
// ============================================================================
// sync_pkg : shared state encoding and sync timing defaults for the
//            transducer phase-alignment path.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam int SYNC_PERIOD_DEFAULT = 1250;
    localparam int SYNC_TOL_DEFAULT    = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HUNT     = 3'd1,
        LOCKING  = 3'd2,
        LOCKED   = 3'd3,
        HOLDOVER = 3'd4
    } sync_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_window_cnt.sv
// ============================================================================
// sync_window_cnt : saturating period counter with sync acceptance-window flags.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sync_window_cnt #(
    parameter int PERIOD = 1250,
    parameter int TOL    = 2,
    parameter int CNT_W  = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic restart,
    input  logic load_grid,
    output logic early,
    output logic in_window,
    output logic nominal,
    output logic timeout,
    output logic near_start
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] NOM      = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] GRID_LD  = CNT_W'(TOL + 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] NEAR_MAX = CNT_W'(TOL);

    logic [CNT_W-1:0] cnt;

    // The event cycle itself is count 0, so the cycle after an event reads 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= ONE;
        end else if (load_grid) begin
            cnt <= GRID_LD;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + ONE;
        end
    end

    assign early      = (cnt < WIN_LO);
    assign in_window  = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    assign nominal    = (cnt == NOM);
    assign timeout    = (cnt == WIN_HI);
    assign near_start = (cnt <= NEAR_MAX);

endmodule

`default_nettype wire

// File: rtl/sync_lock_ctrl.sv
// ============================================================================
// sync_lock_ctrl : sync qualification, lock acquisition, holdover and
//                  phase_reset sequencing. Optional SYNC_LOCK_CTRL_STATS_EN.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sync_lock_ctrl
    import sync_pkg::*;
#(
    parameter int PERIOD     = SYNC_PERIOD_DEFAULT,
    parameter int TOL        = SYNC_TOL_DEFAULT,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sync_pulse,
    output logic        phase_reset,
    output logic        locked,
    output logic        holdover,
    output logic        lost_sync,
`ifdef SYNC_LOCK_CTRL_STATS_EN
    output logic [15:0] reject_count,
    output logic [15:0] holdover_count,
`endif
    output logic [2:0]  state
);

    localparam int CNT_W  = $clog2(PERIOD + TOL + 2);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    sync_state_t       cur_state;
    logic [GOOD_W-1:0] good;
    logic [MISS_W-1:0] miss;

    logic early, in_window, nominal, timeout, near_start;
    logic cnt_clear, cnt_restart, cnt_load_grid;
    logic hold_accept, miss_spent, lock_reached;

    sync_window_cnt #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .CNT_W  (CNT_W)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .restart    (cnt_restart),
        .load_grid  (cnt_load_grid),
        .early      (early),
        .in_window  (in_window),
        .nominal    (nominal),
        .timeout    (timeout),
        .near_start (near_start)
    );

    // Near-start acceptance only arises right after an internal event, since
    // holdover entry loads the counter past TOL.
    assign hold_accept  = sync_pulse && (!early || near_start);
    assign miss_spent   = (miss == MISS_W'(MISS_LIMIT));
    assign lock_reached = (good == GOOD_W'(LOCK_COUNT - 1));

    always_comb begin
        cnt_clear     = !enable || (cur_state == IDLE);
        cnt_restart   = 1'b0;
        cnt_load_grid = 1'b0;
        case (cur_state)
            HUNT, LOCKING: cnt_restart = sync_pulse;
            LOCKED: begin
                cnt_restart   = sync_pulse && in_window;
                cnt_load_grid = timeout && !(sync_pulse && in_window);
            end
            HOLDOVER: cnt_restart = hold_accept || (nominal && !miss_spent);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state   <= IDLE;
            good        <= '0;
            miss        <= '0;
            phase_reset <= 1'b0;
            locked      <= 1'b0;
            holdover    <= 1'b0;
            lost_sync   <= 1'b0;
        end else begin
            phase_reset <= 1'b0;
            lost_sync   <= 1'b0;
            if (!enable) begin
                cur_state <= IDLE;
                good      <= '0;
                miss      <= '0;
                locked    <= 1'b0;
                holdover  <= 1'b0;
            end else begin
                case (cur_state)
                    IDLE: cur_state <= HUNT;
                    HUNT: begin
                        if (sync_pulse) begin
                            cur_state   <= LOCKING;
                            good        <= GOOD_W'(1);
                            phase_reset <= 1'b1;
                        end
                    end
                    LOCKING: begin
                        if (sync_pulse) begin
                            phase_reset <= 1'b1;
                            if (early) begin
                                good <= GOOD_W'(1);
                            end else begin
                                good <= good + GOOD_W'(1);
                                if (lock_reached) begin
                                    cur_state <= LOCKED;
                                    locked    <= 1'b1;
                                end
                            end
                        end else if (timeout) begin
                            cur_state <= HUNT;
                            good      <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sync_pulse && in_window) begin
                            phase_reset <= 1'b1;
                        end else if (timeout) begin
                            cur_state <= HOLDOVER;
                            holdover  <= 1'b1;
                            miss      <= MISS_W'(1);
                        end
                    end
                    HOLDOVER: begin
                        if (hold_accept) begin
                            cur_state   <= LOCKED;
                            holdover    <= 1'b0;
                            miss        <= '0;
                            phase_reset <= 1'b1;
                        end else if (nominal) begin
                            if (miss_spent) begin
                                cur_state <= HUNT;
                                locked    <= 1'b0;
                                holdover  <= 1'b0;
                                lost_sync <= 1'b1;
                                miss      <= '0;
                                good      <= '0;
                            end else begin
                                miss        <= miss + MISS_W'(1);
                                phase_reset <= 1'b1;
                            end
                        end
                    end
                    default: cur_state <= IDLE;
                endcase
            end
        end
    end

    assign state = cur_state;

`ifdef SYNC_LOCK_CTRL_STATS_EN
    logic reject_evt, holdover_entry;

    assign reject_evt = sync_pulse &&
                        (((cur_state == LOCKING) && early) ||
                         ((cur_state == LOCKED) && !in_window) ||
                         ((cur_state == HOLDOVER) && !hold_accept));
    assign holdover_entry = (cur_state == LOCKED) && cnt_load_grid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reject_count   <= '0;
            holdover_count <= '0;
        end else if (!enable) begin
            reject_count   <= '0;
            holdover_count <= '0;
        end else begin
            if (reject_evt && (reject_count != 16'hFFFF)) begin
                reject_count <= reject_count + 16'd1;
            end
            if (holdover_entry && (holdover_count != 16'hFFFF)) begin
                holdover_count <= holdover_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
